dec_result_formatter: RTL and testbench

- Downstream stage of the decimal floating-point adder. Consumes a finished result and converts it to display-ready BCD.
- Input result format: sign, 34-bit binary mantissa, signed 7-bit decimal exponent. The value is (-1)^sign × mant × 10^exp.
- Output: 11 BCD digits, a significant-digit count and a trailing-zero-stripped exponent.
- The display driver reads the outputs on the done pulse.

---
 rtl/dec_result_formatter.sv | 161 ++++++++++++++++
 tb/tb_dec_result_formatter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dec_result_formatter.sv
`default_nettype none
// ============================================================================
// Module  : dec_result_formatter
// Purpose : Converts a binary-mantissa decimal result to BCD digits, strips
//           trailing zeros into the exponent and reports the digit count.
// Revision: 1.0 - initial release
// ============================================================================
module dec_result_formatter #(
  parameter int MANT_W = 34,
  parameter int EXP_W  = 7,
  parameter int NDIG   = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signIn,
  input  logic [MANT_W-1:0]      mantIn,
  input  logic [EXP_W-1:0]       expIn,
  output logic                   busy,
  output logic                   done,
  output logic                   signOut,
  output logic [4*NDIG-1:0]      digitsOut,
  output logic [3:0]             numDigits,
  output logic [EXP_W-1:0]       expOut
);

  localparam int c_BCD_W = 4 * NDIG;
  localparam int c_CNT_W = $clog2(MANT_W + 1);
  localparam logic signed [EXP_W-1:0] c_EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_TRIM    = 3'd2,
    S_FINAL   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic                      r_startPrev;
  logic                      r_sign;
  logic [MANT_W-1:0]         r_mant;
  logic signed [EXP_W-1:0]   r_exp;
  logic [c_BCD_W-1:0]        r_bcd;
  logic [c_CNT_W-1:0]        r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_signOut;
  logic [c_BCD_W-1:0]        r_digitsOut;
  logic [3:0]                r_numDigits;
  logic [EXP_W-1:0]          r_expOut;

  logic                      w_accept;
  logic                      w_trim;
  logic                      w_isZero;
  logic [c_BCD_W-1:0]        w_adj;
  logic [3:0]                w_numDigits;

  assign w_accept = start & ~r_startPrev;
  assign w_isZero = (r_bcd == '0);
  assign w_trim   = !w_isZero && (r_bcd[3:0] == 4'd0) && (r_exp < c_EXP_MAX);

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_numDigits = 4'd1;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0)
        w_numDigits = 4'(i + 1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_nextState = S_CONVERT;
      S_CONVERT: if (r_cnt == c_CNT_W'(1)) w_nextState = S_TRIM;
      S_TRIM:    if (!w_trim) w_nextState = S_FINAL;
      S_FINAL:   w_nextState = S_DONE;
      S_DONE:    w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_startPrev <= 1'b0;
      r_sign      <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_signOut   <= 1'b0;
      r_digitsOut <= '0;
      r_numDigits <= 4'd1;
      r_expOut    <= '0;
    end else begin
      r_startPrev <= start;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= signIn;
            r_mant <= mantIn;
            r_exp  <= expIn;
            r_bcd  <= '0;
            r_cnt  <= c_CNT_W'(MANT_W);
            r_busy <= 1'b1;
          end
        end
        S_CONVERT: begin
          r_bcd  <= {w_adj[c_BCD_W-2:0], r_mant[MANT_W-1]};
          r_mant <= {r_mant[MANT_W-2:0], 1'b0};
          r_cnt  <= r_cnt - c_CNT_W'(1);
        end
        S_TRIM: begin
          if (w_trim) begin
            r_bcd <= {4'd0, r_bcd[c_BCD_W-1:4]};
            r_exp <= r_exp + EXP_W'(1);
          end
        end
        S_FINAL: begin
          r_digitsOut <= r_bcd;
          r_numDigits <= w_numDigits;
          // A zero result is always reported as +0 x 10^0.
          r_signOut   <= w_isZero ? 1'b0 : r_sign;
          r_expOut    <= w_isZero ? '0 : r_exp;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign signOut   = r_signOut;
  assign digitsOut = r_digitsOut;
  assign numDigits = r_numDigits;
  assign expOut    = r_expOut;

endmodule
`default_nettype wire

// File: tb/tb_dec_result_formatter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dec_result_formatter
// Purpose : Directed self-checking bench for dec_result_formatter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dec_result_formatter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signIn;
  logic [33:0] mantIn;
  logic [6:0]  expIn;
  logic        busy;
  logic        done;
  logic        signOut;
  logic [43:0] digitsOut;
  logic [3:0]  numDigits;
  logic [6:0]  expOut;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  dec_result_formatter dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .signIn    (signIn),
    .mantIn    (mantIn),
    .expIn     (expIn),
    .busy      (busy),
    .done      (done),
    .signOut   (signOut),
    .digitsOut (digitsOut),
    .numDigits (numDigits),
    .expOut    (expOut)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chkOutputs(input string tag, input logic [43:0] d, input logic [3:0] nd,
                            input logic [6:0] e, input logic s);
    chk({tag, ".digits"}, 64'(digitsOut), 64'(d));
    chk({tag, ".numDigits"}, 64'(numDigits), 64'(nd));
    chk({tag, ".expOut"}, 64'(expOut), 64'(e));
    chk({tag, ".signOut"}, 64'(signOut), 64'(s));
  endtask

  // One conversion: launch, then count edges from acceptance until done.
  task automatic convert(input string tag, input logic s, input logic [33:0] m,
                         input logic [6:0] e, input int lat, input logic [43:0] d,
                         input logic [3:0] nd, input logic [6:0] eo, input logic so);
    int  n;
    bit  seen;
    bit  busyOk;
    @(negedge clock);
    signIn = s; mantIn = m; expIn = e; start = 1'b1;
    @(posedge clock);
    n = 0; seen = 0; busyOk = 1;
    while (!seen && n < 200) begin
      @(posedge clock);
      n++;
      #1;
      if (n == 3) start = 1'b0;
      if (done) seen = 1;
      else if (!busy) busyOk = 0;
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".busyDuring"}, 64'(busyOk), 64'd1);
    chk({tag, ".busyAtDone"}, 64'(busy), 64'd0);
    chkOutputs(tag, d, nd, eo, so);
    @(posedge clock);
    #1;
    chk({tag, ".donePulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int doneCount;
    int doneAt;
    bit busyOk;

    reset = 1'b1; start = 1'b0; signIn = 1'b0; mantIn = '0; expIn = '0;
    #12;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chkOutputs("reset", 44'h0, 4'd1, 7'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    convert("max", 1'b0, 34'd17179869183, 7'd0, 37, 44'h17179869183, 4'd11, 7'd0, 1'b0);
    convert("trim2", 1'b1, 34'd1500, -7'sd2, 39, 44'h15, 4'd2, 7'd0, 1'b1);
    convert("zero", 1'b1, 34'd0, 7'd5, 37, 44'h0, 4'd1, 7'd0, 1'b0);
    convert("expcap", 1'b0, 34'd10000000000, 7'd60, 40, 44'h10000000, 4'd8, 7'd63, 1'b0);
    convert("seven", 1'b1, 34'd7, -7'sd64, 37, 44'h7, 4'd1, -7'sd64, 1'b1);

    // Start held high with a glitch-induced second edge while busy.
    @(negedge clock);
    signIn = 1'b1; mantIn = 34'd123456789; expIn = 7'd3; start = 1'b1;
    @(posedge clock);
    doneCount = 0; doneAt = 0; busyOk = 1;
    for (n = 1; n <= 110; n++) begin
      @(posedge clock);
      #1;
      if (done) begin doneCount++; doneAt = n; end
      if (n < 37 && !busy) busyOk = 0;
      if (n == 19) start = 1'b0;
      if (n == 20) begin start = 1'b1; mantIn = 34'd999; signIn = 1'b0; expIn = 7'd0; end
      if (n == 100) start = 1'b0;
    end
    chk("hold.doneCount", 64'(doneCount), 64'd1);
    chk("hold.doneAt", 64'(doneAt), 64'd37);
    chk("hold.busy", 64'(busyOk), 64'd1);
    chkOutputs("hold", 44'h123456789, 4'd9, 7'd3, 1'b1);

    // Reset mid-conversion abandons the work.
    @(negedge clock);
    signIn = 1'b1; mantIn = 34'd555; expIn = 7'd1; start = 1'b1;
    @(posedge clock);
    for (n = 1; n <= 16; n++) begin
      @(posedge clock);
      #1;
      if (n == 3) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.done", 64'(done), 64'd0);
    chkOutputs("midreset", 44'h0, 4'd1, 7'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    doneCount = 0;
    for (n = 0; n < 60; n++) begin
      @(posedge clock);
      #1;
      if (done || busy) doneCount++;
    end
    chk("midreset.noDone", 64'(doneCount), 64'd0);
    convert("after", 1'b0, 34'd42, 7'd0, 37, 44'h42, 4'd2, 7'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
